mmio_responder: RTL and testbench

- Peripheral-side slave for the data-memory MMIO window (CPU addresses 0x00007f00–0x00007fff).
- Receives the byte address, write data and read/write strobes that the data-cache front end routes off-chip. Returns read data combinationally in the same cycle.
- Implements the board I/O: LED register, a buffered input stream with a FIFO, a one-entry output stream with a ready/valid handshake, and a cycle counter.

---
 rtl/mmio_pkg.sv | 43 ++++
 rtl/mmio_in_fifo.sv | 63 ++++++
 rtl/mmio_responder.sv | 135 +++++++++++++
 tb/tb_mmio_responder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO window responder: register offsets, base, status bits
// and the offset decoder used by the top level.
package mmio_pkg;

    localparam logic [7:0]  MMIO_LED      = 8'h00;
    localparam logic [7:0]  MMIO_IN_STAT  = 8'h04;
    localparam logic [7:0]  MMIO_IN_DATA  = 8'h08;
    localparam logic [7:0]  MMIO_OUT_STAT = 8'h0C;
    localparam logic [7:0]  MMIO_OUT_DATA = 8'h10;
    localparam logic [7:0]  MMIO_CYCLE    = 8'h14;

    // Upper CPU address bits selecting the window 0x00007f00-0x00007fff.
    localparam logic [23:0] MMIO_BASE     = 24'h00007f;

    localparam int IN_STAT_NE_BIT   = 0;
    localparam int IN_STAT_CNT_LSB  = 8;
    localparam int OUT_STAT_RDY_BIT = 0;
    localparam int OUT_STAT_OVF_BIT = 1;

    typedef enum logic [2:0] {
        REG_LED,
        REG_IN_STAT,
        REG_IN_DATA,
        REG_OUT_STAT,
        REG_OUT_DATA,
        REG_CYCLE,
        REG_NONE
    } reg_sel_e;

    // Word decode only; the byte lane bits never select a register.
    function automatic reg_sel_e decode_reg(input logic [5:0] word);
        reg_sel_e sel;
        sel = REG_NONE;
        if (word == MMIO_LED[7:2])           sel = REG_LED;
        else if (word == MMIO_IN_STAT[7:2])  sel = REG_IN_STAT;
        else if (word == MMIO_IN_DATA[7:2])  sel = REG_IN_DATA;
        else if (word == MMIO_OUT_STAT[7:2]) sel = REG_OUT_STAT;
        else if (word == MMIO_OUT_DATA[7:2]) sel = REG_OUT_DATA;
        else if (word == MMIO_CYCLE[7:2])    sel = REG_CYCLE;
        return sel;
    endfunction

endpackage

// File: rtl/mmio_in_fifo.sv
// Synchronous input-stream FIFO: registered pointers and count, combinational head.
module mmio_in_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  din_i,
    output logic [W-1:0]  head_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so natural pointer overflow is the wrap.
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/mmio_responder.sv
// MMIO window slave: LED register, input FIFO, one-entry output stream, optional cycle
// counter enabled by defining MMIO_CYCLE_CNT_EN.
module mmio_responder
    import mmio_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int LED_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       io_addr,
    input  logic [31:0]      io_dout,
    input  logic             io_we,
    input  logic             io_rd,
    output logic [31:0]      io_din,
    output logic [LED_W-1:0] led,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [31:0]      out_data,
    input  logic             out_ready
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    reg_sel_e      sel;
    logic [1:0]    unused_lane;

    logic [LED_W-1:0] led_q, led_d;
    logic          out_valid_q, out_valid_d;
    logic [31:0]   out_data_q, out_data_d;
    logic          ovf_q, ovf_d;

    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [31:0]   fifo_head;
    logic [CW-1:0] fifo_count;
    logic          out_wr, out_accept;
    logic [31:0]   cycle_rd;

    assign sel         = decode_reg(io_addr[7:2]);
    assign unused_lane = io_addr[1:0];

    // in_ready is forced low during reset so nothing is pushed into a clearing FIFO.
    assign in_ready  = ~fifo_full & ~rst;
    assign fifo_push = in_valid & in_ready;
    assign fifo_pop  = io_rd & (sel == REG_IN_DATA) & ~fifo_empty;

    mmio_in_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (32),
        .CW    (CW)
    ) u_in_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   (in_data),
        .head_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign out_wr     = io_we & (sel == REG_OUT_DATA);
    assign out_accept = ~out_valid_q | out_ready;

    always_comb begin
        led_d       = led_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        ovf_d       = ovf_q;
        if (io_we && sel == REG_LED) led_d = io_dout[LED_W-1:0];
        if (io_we && sel == REG_OUT_STAT) ovf_d = 1'b0;
        // A same-cycle accepted write reloads the slot the consumer is draining.
        if (out_wr && out_accept) begin
            out_valid_d = 1'b1;
            out_data_d  = io_dout;
        end else begin
            if (out_wr) ovf_d = 1'b1;
            if (out_valid_q && out_ready) out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            ovf_q       <= 1'b0;
        end else begin
            led_q       <= led_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            ovf_q       <= ovf_d;
        end
    end

`ifdef MMIO_CYCLE_CNT_EN
    logic [31:0] cycle_q, cycle_d;

    assign cycle_d  = (io_we && sel == REG_CYCLE) ? 32'd0 : cycle_q + 32'd1;
    assign cycle_rd = cycle_q;

    always_ff @(posedge clk) begin
        if (rst) cycle_q <= '0;
        else     cycle_q <= cycle_d;
    end
`else
    assign cycle_rd = 32'd0;
`endif

    always_comb begin
        io_din = 32'd0;
        case (sel)
            REG_LED:      io_din = 32'(led_q);
            REG_IN_STAT: begin
                io_din[IN_STAT_NE_BIT] = ~fifo_empty;
                io_din[IN_STAT_CNT_LSB +: CW] = fifo_count;
            end
            REG_IN_DATA:  io_din = fifo_empty ? 32'd0 : fifo_head;
            REG_OUT_STAT: begin
                io_din[OUT_STAT_RDY_BIT] = ~out_valid_q;
                io_din[OUT_STAT_OVF_BIT] = ovf_q;
            end
            REG_OUT_DATA: io_din = out_data_q;
            REG_CYCLE:    io_din = cycle_rd;
            default:      io_din = 32'd0;
        endcase
    end

    assign led       = led_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_mmio_responder.sv
// Scoreboard bench for mmio_responder: stimulus queues expected values, a negedge
// monitor pops and compares load data, output-stream handshakes and signal probes.
module tb_mmio_responder;
    import mmio_pkg::*;

    typedef struct {
        logic [31:0] v;
        int          sel;
        string       nm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  io_addr = '0;
    logic [31:0] io_dout = '0;
    logic        io_we = 1'b0;
    logic        io_rd = 1'b0;
    logic [31:0] io_din;
    logic [15:0] led;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready = 1'b0;
    logic        prb = 1'b0;

    exp_t rdq[$];
    exp_t outq[$];
    exp_t prq[$];
    int   nvec = 0;
    int   nmis = 0;

`ifdef MMIO_CYCLE_CNT_EN
    localparam bit CYC_EN = 1'b1;
`else
    localparam bit CYC_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    mmio_responder #(.FIFO_DEPTH(4), .LED_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .io_addr   (io_addr),
        .io_dout   (io_dout),
        .io_we     (io_we),
        .io_rd     (io_rd),
        .io_din    (io_din),
        .led       (led),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    // Monitor: inputs change #1 after posedge, so negedge sees settled combinational outputs.
    always @(negedge clk) begin
        exp_t e;
        logic [31:0] act;
        if (io_rd) begin
            if (rdq.size() == 0) begin
                nvec++; nmis++;
                $display("FAIL unexpected_load: got %08h expected no load", io_din);
            end else begin
                e = rdq.pop_front();
                cmp(e.nm, io_din, e.v);
            end
        end
        if (out_valid && out_ready) begin
            if (outq.size() == 0) begin
                nvec++; nmis++;
                $display("FAIL unexpected_out: got %08h expected no handshake", out_data);
            end else begin
                e = outq.pop_front();
                cmp(e.nm, out_data, e.v);
            end
        end
        if (prb) begin
            if (prq.size() == 0) begin
                nvec++; nmis++;
                $display("FAIL probe_underflow: got probe expected none");
            end else begin
                e = prq.pop_front();
                case (e.sel)
                    0:       act = 32'(led);
                    1:       act = 32'(in_ready);
                    2:       act = 32'(out_valid);
                    default: act = out_data;
                endcase
                cmp(e.nm, act, e.v);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        io_addr = a; io_dout = d; io_we = 1'b1;
        step();
        io_we = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string nm);
        exp_t e;
        e.v = exp; e.sel = 0; e.nm = nm;
        rdq.push_back(e);
        io_addr = a; io_rd = 1'b1;
        step();
        io_rd = 1'b0;
    endtask

    task automatic wrrd(input logic [7:0] a, input logic [31:0] d, input logic [31:0] exp,
                        input string nm);
        exp_t e;
        e.v = exp; e.sel = 0; e.nm = nm;
        rdq.push_back(e);
        io_addr = a; io_dout = d; io_we = 1'b1; io_rd = 1'b1;
        step();
        io_we = 1'b0; io_rd = 1'b0;
    endtask

    task automatic probe(input int s, input logic [31:0] exp, input string nm);
        exp_t e;
        e.v = exp; e.sel = s; e.nm = nm;
        prq.push_back(e);
        prb = 1'b1;
        step();
        prb = 1'b0;
    endtask

    task automatic push(input logic [31:0] d);
        in_valid = 1'b1; in_data = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input logic [31:0] d, input string nm);
        exp_t e;
        e.v = d; e.sel = 0; e.nm = nm;
        outq.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] fillv [4];
        fillv[0] = 32'hA0; fillv[1] = 32'hA1; fillv[2] = 32'hA2; fillv[3] = 32'hA3;

        step();
        probe(0, 32'h0, "rst_led");
        probe(1, 32'h0, "rst_in_ready_low");
        probe(2, 32'h0, "rst_out_valid");
        rst = 1'b0;

        // Counter: value equals edges since release.
        repeat (10) step();
        rd(MMIO_CYCLE, CYC_EN ? 32'd10 : 32'd0, "cycle_10");
        wr(MMIO_CYCLE, 32'hFFFF_FFFF);
        step();
        rd(MMIO_CYCLE, CYC_EN ? 32'd1 : 32'd0, "cycle_clear");
        probe(1, 32'h1, "in_ready_after_rst");

        wr(MMIO_LED, 32'h1234_ABCD);
        probe(0, 32'h0000_ABCD, "led_pin");
        rd(MMIO_LED, 32'h0000_ABCD, "led_read");
        rd(8'h03, 32'h0000_ABCD, "led_lane_ignored");
        wr(8'h18, 32'hDEAD_BEEF);
        rd(8'h18, 32'h0, "unmapped_read");
        rd(MMIO_LED, 32'h0000_ABCD, "led_after_unmapped_wr");

        push(32'h11); push(32'h22); push(32'h33); push(32'h44);
        probe(1, 32'h0, "in_ready_full");
        rd(MMIO_IN_STAT, 32'h0000_0401, "in_stat_full");
        rd(MMIO_IN_DATA, 32'h11, "pop_11");
        rd(MMIO_IN_DATA, 32'h22, "pop_22");
        probe(1, 32'h1, "in_ready_after_pop");
        rd(MMIO_IN_STAT, 32'h0000_0201, "in_stat_2");
        rd(MMIO_IN_DATA, 32'h33, "pop_33");
        rd(MMIO_IN_DATA, 32'h44, "pop_44");
        rd(MMIO_IN_DATA, 32'h0, "pop_empty");
        rd(MMIO_IN_STAT, 32'h0, "in_stat_empty");

        in_valid = 1'b1; in_data = 32'h55;
        rd(MMIO_IN_DATA, 32'h0, "pop_push_empty");
        in_valid = 1'b0;
        rd(MMIO_IN_STAT, 32'h0000_0101, "in_stat_push_landed");
        push(32'h66);
        in_valid = 1'b1; in_data = 32'h77;
        rd(MMIO_IN_DATA, 32'h55, "pop_push_same");
        in_valid = 1'b0;
        rd(MMIO_IN_STAT, 32'h0000_0201, "in_stat_unchanged");
        rd(MMIO_IN_DATA, 32'h66, "pop_66");
        rd(MMIO_IN_DATA, 32'h77, "pop_77");

        // Full FIFO must refuse a fifth word.
        for (int i = 0; i < 4; i++) push(fillv[i]);
        push(32'hA4);
        for (int i = 0; i < 4; i++) rd(MMIO_IN_DATA, fillv[i], "pop_fill");
        rd(MMIO_IN_STAT, 32'h0, "full_push_dropped");

        rd(MMIO_OUT_STAT, 32'h1, "out_stat_idle");
        wr(MMIO_OUT_DATA, 32'hA5);
        probe(2, 32'h1, "out_valid_set");
        probe(3, 32'hA5, "out_data_a5");
        rd(MMIO_OUT_STAT, 32'h0, "out_stat_busy");
        wr(MMIO_OUT_DATA, 32'hB6);
        rd(MMIO_OUT_STAT, 32'h2, "out_stat_ovf");
        rd(MMIO_OUT_DATA, 32'hA5, "out_data_kept");
        wr(MMIO_OUT_STAT, 32'h0);
        rd(MMIO_OUT_STAT, 32'h0, "out_stat_ovf_clr");

        expect_out(32'hA5, "hs_a5");
        expect_out(32'hC7, "hs_c7");
        out_ready = 1'b1;
        wr(MMIO_OUT_DATA, 32'hC7);
        rd(MMIO_OUT_STAT, 32'h0, "reload_no_ovf");
        out_ready = 1'b0;
        rd(MMIO_OUT_STAT, 32'h1, "out_drained");
        probe(2, 32'h0, "out_valid_clr");

        wrrd(MMIO_LED, 32'h5A5A, 32'h0000_ABCD, "we_rd_pre_edge");
        rd(MMIO_LED, 32'h0000_5A5A, "we_rd_post");

        push(32'h99);
        wr(MMIO_OUT_DATA, 32'h12);
        rst = 1'b1;
        step();
        rst = 1'b0;
        rd(MMIO_IN_STAT, 32'h0, "rst_fifo_flush");
        rd(MMIO_OUT_STAT, 32'h1, "rst_out_flush");
        rd(MMIO_OUT_DATA, 32'h0, "rst_out_data");
        rd(MMIO_LED, 32'h0, "rst_led_clr");

        step(); step();
        cmp("queues_drained", 32'(rdq.size() + outq.size() + prq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
